// File: rtl/full_subtractor_d_pkg.sv
// Shared constants for the full_subtractor_d leaf cell.
`default_nettype none

package full_subtractor_d_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;
    localparam int unsigned CNT_W_MAX     = 32;

endpackage

`default_nettype wire

// File: rtl/full_subtractor_d_fs_core.sv
// Purely combinational 1-bit full subtractor: a - b - borrow_in.
`default_nettype none

module fs_core (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic d,
    output logic borrow_out
);

    assign d          = a ^ b ^ borrow_in;
    // Borrow when b exceeds a, or when they tie and a borrow arrives from below.
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

`default_nettype wire

// File: rtl/full_subtractor_d.sv
// Full subtractor leaf cell with registered observation copies and a saturating borrow counter.
`default_nettype none

module full_subtractor_d
    import full_subtractor_d_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             borrow_in,
    output logic             d,
    output logic             borrow_out,
    output logic             d_q,
    output logic             borrow_out_q,
    output logic [CNT_W-1:0] borrow_cnt
);

    fs_core u_core (
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .d          (d),
        .borrow_out (borrow_out)
    );

    // Counter saturates at all-ones so long borrow runs never alias to small counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q          <= 1'b0;
            borrow_out_q <= 1'b0;
            borrow_cnt   <= '0;
        end else begin
            d_q          <= d;
            borrow_out_q <= borrow_out;
            if (borrow_out && (borrow_cnt != {CNT_W{1'b1}})) begin
                borrow_cnt <= borrow_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_full_subtractor_d.sv
// Self-checking bench for full_subtractor_d: literal table pins plus an arithmetic reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_full_subtractor_d;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a = 1'b0, b = 1'b0, bin = 1'b0;
    logic             d, bout, d_q, bout_q;
    logic [CNT_W-1:0] cnt;

    bit clk_run = 1'b0;
    bit chk_en  = 1'b0;
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (arithmetic view of the registered stage)
    int m_dq  = 0;
    int m_bq  = 0;
    int m_cnt = 0;

    full_subtractor_d #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .b            (b),
        .borrow_in    (bin),
        .d            (d),
        .borrow_out   (bout),
        .d_q          (d_q),
        .borrow_out_q (bout_q),
        .borrow_cnt   (cnt)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int arith(input logic x, input logic y, input logic z);
        return int'(x) - int'(y) - int'(z);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dq = 0; m_bq = 0; m_cnt = 0;
        end else begin
            int diff;
            diff  = arith(a, b, bin);
            m_dq  = diff & 1;
            m_bq  = (diff < 0) ? 1 : 0;
            if (diff < 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic signed [1:0] pair;
            pair = {bout, d};
            check("arith", 32'(int'(pair)), 32'(arith(a, b, bin)));
            check("d_q", 32'(d_q), 32'(m_dq));
            check("borrow_out_q", 32'(bout_q), 32'(m_bq));
            check("borrow_cnt", 32'(cnt), 32'(m_cnt));
        end
    end

    // Truth table: index {a,b,bin} -> {d,bout}
    logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    initial begin
        // 1: clk idle, combinational sweep against the literal table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {a, b, bin} = v;
            #20;
            check("tt_d", 32'(d), 32'(tt[i][1]));
            check("tt_bout", 32'(bout), 32'(tt[i][0]));
        end

        // 2: in reset, comb still correct and registers cleared
        for (int i = 7; i >= 0; i--) begin
            logic [2:0] v;
            v = 3'(i);
            {a, b, bin} = v;
            #20;
            check("rst_d", 32'(d), 32'(tt[i][1]));
            check("rst_bout", 32'(bout), 32'(tt[i][0]));
            check("rst_d_q", 32'(d_q), 32'd0);
            check("rst_bout_q", 32'(bout_q), 32'd0);
            check("rst_cnt", 32'(cnt), 32'd0);
        end

        // 3: release reset, two directed vectors
        clk_run = 1'b1;
        @(negedge clk); #1;
        {a, b, bin} = 3'b101;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("dir1_d_q", 32'(d_q), 32'd0);
        check("dir1_bout_q", 32'(bout_q), 32'd0);
        {a, b, bin} = 3'b010;
        @(posedge clk); #1;
        check("dir2_d_q", 32'(d_q), 32'd1);
        check("dir2_bout_q", 32'(bout_q), 32'd1);
        check("dir2_cnt", 32'(cnt), 32'd1);

        // 4: saturation over 300 borrowing edges
        @(negedge clk); #1;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        {a, b, bin} = 3'b010;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (k == 254) check("sat_254", 32'(cnt), 32'd254);
            if (k == 255) check("sat_255", 32'(cnt), 32'd255);
            if (k == 300) check("sat_300", 32'(cnt), 32'd255);
        end

        // 5: asynchronous reset pulse between edges with count 17
        @(negedge clk); #1;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        for (int k = 0; k < 17; k++) @(posedge clk);
        #1;
        check("pre_cnt17", 32'(cnt), 32'd17);
        check("pre_d_q", 32'(d_q), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_cnt", 32'(cnt), 32'd0);
        check("async_d_q", 32'(d_q), 32'd0);
        check("async_bout_q", 32'(bout_q), 32'd0);
        check("async_comb_d", 32'(d), 32'd1);
        rst_n = 1'b1;
        #1;
        check("post_cnt", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        check("deassert_cnt", 32'(cnt), 32'd1);

        // 6: random vectors against the arithmetic model
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk); #1;
            {a, b, bin} = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
